// File: rtl/disp_frame_capture.sv
// disp_frame_capture
//   Receiving end of the display row stream. Row words arrive one per clk_1
//   tick as (in_addr, in_data). The block assembles a complete ROWS x COLS
//   frame in a shadow buffer, then commits it atomically to the committed
//   buffer that the display side reads. A frame is only committed when rows
//   0..ROWS-1 arrive strictly in order, so rd_data never shows a torn frame.
//
// Handshake: in_valid qualifies in_addr/in_data on the sampling edge; there
//   is no back-pressure (no ready), so every valid word is consumed on the
//   edge where in_valid is high, and nothing happens while it is low.
//
// Ports
//   clk_1      in   stream clock, all state changes on posedge
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_addr/in_data are sampled this edge
//   in_addr    in   [3:0] row address of the incoming word
//   in_data    in   [COLS-1:0] row data, bit i = column i
//   rd_addr    in   [3:0] committed-buffer read row
//   rd_data    out  [COLS-1:0] committed row at rd_addr (combinational)
//   frame_done out  one-cycle pulse after a commit edge
//   frame_cnt  out  [7:0] committed frame count, wraps 255 -> 0
//   full_rows  out  [3:0] all-ones rows in the last committed frame
//   seq_err    out  one-cycle pulse after an out-of-sequence word
module disp_frame_capture #(
    parameter int ROWS = 10,
    parameter int COLS = 10
) (
    input  logic            clk_1,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      in_addr,
    input  logic [COLS-1:0] in_data,
    input  logic [3:0]      rd_addr,
    output logic [COLS-1:0] rd_data,
    output logic            frame_done,
    output logic [7:0]      frame_cnt,
    output logic [3:0]      full_rows,
    output logic            seq_err
);

    localparam logic [0:0] ST_SYNC = 1'b0;  // hunting for a row-0 word
    localparam logic [0:0] ST_CAPT = 1'b1;  // capturing rows in order

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [4:0] ROWS_W   = 5'(ROWS);

    logic [0:0]      state;
    logic [3:0]      exp;
    // Arrays span the whole 4-bit address space; rows at or above ROWS are
    // never written and stay zero.
    logic [COLS-1:0] shadow    [16];
    logic [COLS-1:0] committed [16];
    logic [3:0]      full_cnt;

    // All-ones rows of the frame being committed: the earlier rows come from
    // the shadow, the final row is the word arriving on the commit edge.
    always_comb begin
        full_cnt = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            if (&shadow[r]) full_cnt = full_cnt + 4'd1;
        end
        if (&in_data) full_cnt = full_cnt + 4'd1;
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < ROWS_W) rd_data = committed[rd_addr];
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state      <= ST_SYNC;
            exp        <= '0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            frame_cnt  <= '0;
            full_rows  <= '0;
            for (int r = 0; r < 16; r++) begin
                shadow[r]    <= '0;
                committed[r] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            if (in_valid) begin
                case (state)
                    ST_SYNC: begin
                        // Non-zero addresses are skipped silently so joining
                        // the stream mid-frame raises no error.
                        if (in_addr == 4'd0) begin
                            shadow[0] <= in_data;
                            exp       <= 4'd1;
                            state     <= ST_CAPT;
                        end
                    end
                    default: begin
                        if (in_addr == exp) begin
                            if (exp == LAST_ROW) begin
                                for (int r = 0; r < ROWS - 1; r++) begin
                                    committed[r] <= shadow[r];
                                end
                                committed[LAST_ROW] <= in_data;
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                full_rows  <= full_cnt;
                                exp        <= '0;
                                state      <= ST_SYNC;
                            end else begin
                                shadow[exp] <= in_data;
                                exp         <= exp + 4'd1;
                            end
                        end else begin
                            // exp is never 0 in capture, so a row-0 word here
                            // is always a break; it restarts the frame.
                            seq_err <= 1'b1;
                            if (in_addr == 4'd0) begin
                                shadow[0] <= in_data;
                                exp       <= 4'd1;
                            end else begin
                                exp   <= '0;
                                state <= ST_SYNC;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/disp_frame_capture.md
Name: disp_frame_capture

Overview:
- Receiving end of the display row stream: a row address plus row data word, advanced once per clk_1 tick by the display-data source.
- Assembles one complete ROWS x COLS frame in a shadow buffer and commits it atomically to a committed buffer.
- The display side reads the committed buffer by row without tearing.
- Also reports frame completion, a wrapping frame count, stream-sequence errors and the number of fully-set rows (line-clear candidates) in each committed frame.

Parameters:
- ROWS, 10, rows per frame; legal range 2..16 (addresses are 4 bits).
- COLS, 10, bits per row word.

Ports:
- clk_1  input  1  stream clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_addr/in_data sampled this edge.
- in_addr  input  4  row address of incoming word.
- in_data  input  COLS  row data; bit i = column i.
- rd_addr  input  4  committed-buffer read row.
- rd_data  output  COLS  committed row at rd_addr; combinational.
- frame_done  output  1  one-cycle pulse on commit.
- frame_cnt  output  8  committed frames, wraps 255->0.
- full_rows  output  4  count of all-ones rows in last committed frame.
- seq_err  output  1  one-cycle pulse on out-of-sequence word.

Behaviour:
- Reset (async, any time, including mid-frame): state=SYNC, exp=0, shadow and committed buffers all 0, frame_done=0, seq_err=0, frame_cnt=0, full_rows=0. The partial frame is discarded.
- in_valid=0: no state change, no pulses, in_addr/in_data ignored.
- State SYNC (hunting for frame start):
  - valid && in_addr==0: shadow[0]<=in_data, exp<=1, go CAPT.
  - valid && in_addr!=0: ignored; no seq_err, so startup mid-stream is silent.
- State CAPT, valid && in_addr==exp && exp<ROWS-1: shadow[exp]<=in_data, exp<=exp+1.
- State CAPT, valid && in_addr==exp==ROWS-1 (commit):
  - committed[r]<=shadow[r] for r<ROWS-1; committed[ROWS-1]<=in_data.
  - frame_done=1 for this one cycle.
  - frame_cnt<=frame_cnt+1, mod 256.
  - full_rows<=number of rows, counting the final in_data row, equal to all-ones COLS bits.
  - Go SYNC with exp=0; a back-to-back addr 0 on the next edge starts the next frame with no gap.
- State CAPT, valid && in_addr!=exp:
  - seq_err=1 for one cycle; committed buffer, frame_cnt and full_rows unchanged.
  - If in_addr==0: restart; shadow[0]<=in_data, exp<=1, stay CAPT.
  - Else (including in_addr>=ROWS): go SYNC.
- frame_done and seq_err are registered pulses, high for exactly the one cycle after the triggering edge, and never both high.
- rd_data:
  - Combinational from the committed buffer.
  - Reflects a new commit immediately after the commit edge, i.e. in the same cycle frame_done is high.
  - rd_addr>=ROWS returns all zeros.
- Shadow contents are never visible on rd_data.
- Stale shadow rows from an aborted frame are harmless: every row is rewritten before the next commit.
- Latency: last row word in -> committed and visible after 1 edge.
- Implementation is fully synchronous to clk_1 except the reset; no internal clock division.

Test Plan:
- Nominal: after reset, stream addr 0..9 with data 1<<addr, valid every cycle.
  - frame_done pulses exactly once, after the addr 9 edge; frame_cnt=1; full_rows=0.
  - rd_addr=3 returns 0000001000; rd_addr=12 returns 0.
- Mid-stream start: stream begins at addr 5 (5,6,7,8,9,0,...,9).
  - No seq_err and no frame_done for 5..9; the frame starting at 0 commits normally; frame_cnt=1.
- Sequence break: after one good frame, send 0,1,2,4.
  - seq_err pulses on the 4; state returns to SYNC; rd_data still shows the first frame; frame_cnt unchanged.
  - Then 0,1,0,1,...,9: seq_err on the second 0, the frame then completes, frame_cnt increments by 1.
- Full rows and gaps: frame with rows 7 and 9 = 1111111111, others arbitrary non-full, in_valid deasserted for 3 cycles between rows 4 and 5.
  - Commits normally; full_rows=2; rd_addr=9 returns 1111111111.
- Reset mid-capture: assert rst asynchronously (between clock edges) after row 6 of frame two.
  - All outputs go to 0 immediately; a subsequent full frame commits with frame_cnt=1.
- Wrap: stream 256 consecutive good frames back-to-back.
  - frame_cnt reads 255 then 0; exactly 256 frame_done pulses, each exactly one cycle wide.
